// File: rtl/pipe_mem_pkg.sv
// ----------------------------------------------------------------------------
// pipe_mem_pkg
// Shared definitions for the pipelined CPU memory responders.
//   - DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   - WAIT_CNT_W              : width of the wait-state counter (LATENCY 0..15)
//   - state_e                 : responder FSM state (idle / wait / respond)
// ----------------------------------------------------------------------------
package pipe_mem_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/pipe_dmem_array.sv
// ----------------------------------------------------------------------------
// pipe_dmem_array
// Register-file data memory, 2**ADDR_W words of DATA_W bits. Contents are not
// reset.
// Optional feature macro: DMEM_DBG_PORT_EN (adds the debug write/read port).
//
// Ports:
//   clk        in   clock
//   cpu_we     in   CPU write strobe
//   cpu_addr   in   CPU write address
//   cpu_wdata  in   CPU write data
//   rd_addr    in   CPU-side asynchronous read address
//   rd_data    out  mem[rd_addr]
//   dbg_we     in   debug write strobe            (DMEM_DBG_PORT_EN)
//   dbg_addr   in   debug write/read address      (DMEM_DBG_PORT_EN)
//   dbg_wdata  in   debug write data              (DMEM_DBG_PORT_EN)
//   dbg_rdata  out  mem[dbg_addr], asynchronous   (DMEM_DBG_PORT_EN)
// ----------------------------------------------------------------------------
module pipe_dmem_array
    import pipe_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
`ifdef DMEM_DBG_PORT_EN
    ,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
`ifdef DMEM_DBG_PORT_EN
        if (dbg_we) begin
            mem[dbg_addr] <= dbg_wdata;
        end
`endif
        // Placed last so a same-address CPU store overrides the debug write.
        if (cpu_we) begin
            mem[cpu_addr] <= cpu_wdata;
        end
    end

    assign rd_data = mem[rd_addr];

`ifdef DMEM_DBG_PORT_EN
    assign dbg_rdata = mem[dbg_addr];
`endif

endmodule

// File: rtl/pipe_dmem_responder.sv
// ----------------------------------------------------------------------------
// pipe_dmem_responder
// Data-memory responder for the CPU load/store port. Accepts one request at a
// time (valid/ready), waits LATENCY cycles, then issues a one-cycle response
// pulse carrying load data (or 0 for a store acknowledge).
// Optional feature macro: DMEM_DBG_PORT_EN (debug preload/inspect port).
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   req_valid  in   CPU request present
//   req_we     in   1 = store, 0 = load
//   req_addr   in   request address
//   req_wdata  in   store data
//   req_ready  out  high in idle; request accepted when valid && ready
//   rsp_valid  out  one-cycle response pulse
//   rsp_rdata  out  load data, 0 on store acknowledge
//   dbg_we     in   debug write strobe            (DMEM_DBG_PORT_EN)
//   dbg_addr   in   debug address                 (DMEM_DBG_PORT_EN)
//   dbg_wdata  in   debug write data              (DMEM_DBG_PORT_EN)
//   dbg_rdata  out  mem[dbg_addr], zero latency   (DMEM_DBG_PORT_EN)
// ----------------------------------------------------------------------------
module pipe_dmem_responder
    import pipe_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata
`ifdef DMEM_DBG_PORT_EN
    ,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata
`endif
);

    state_e                state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  cap_we;
    logic [ADDR_W-1:0]     cap_addr;
    logic [DATA_W-1:0]     cap_wdata;

    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic                  mem_we;

    assign req_ready = (state == StIdle);

    // With LATENCY = 0 the response data is registered on the accept edge, so
    // the read port must look at the live request address while idle.
    assign rd_addr = (state == StIdle) ? req_addr : cap_addr;

    // Store commits on the edge that leaves the response state.
    assign mem_we = (state == StResp) && cap_we;

    pipe_dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .cpu_we    (mem_we),
        .cpu_addr  (cap_addr),
        .cpu_wdata (cap_wdata),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
`ifdef DMEM_DBG_PORT_EN
        ,
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        if (LATENCY > 0) begin
                            state    <= StWait;
                            wait_cnt <= WAIT_CNT_W'(LATENCY - 1);
                        end else begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= req_we ? '0 : rd_data;
                        end
                    end
                end
                StWait: begin
                    if (wait_cnt == '0) begin
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= cap_we ? '0 : rd_data;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                StResp: begin
                    state     <= StIdle;
                    rsp_rdata <= '0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_pipe_dmem_responder
// Directed bench: one responder with LATENCY=2 and one with LATENCY=0 sharing
// clock, reset and (when DMEM_DBG_PORT_EN is defined) the debug write inputs.
// ----------------------------------------------------------------------------
module tb_pipe_dmem_responder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // LATENCY = 2 instance
    logic       req_valid, req_we, req_ready, rsp_valid;
    logic [3:0] req_addr;
    logic [7:0] req_wdata, rsp_rdata;

    // LATENCY = 0 instance
    logic       req_valid0, req_we0, req_ready0, rsp_valid0;
    logic [3:0] req_addr0;
    logic [7:0] req_wdata0, rsp_rdata0;

`ifdef DMEM_DBG_PORT_EN
    logic       dbg_we;
    logic [3:0] dbg_addr;
    logic [7:0] dbg_wdata, dbg_rdata, dbg_rdata0;
`endif

    int tests = 0;
    int fails = 0;

    pipe_dmem_responder #(
        .DATA_W  (8),
        .ADDR_W  (4),
        .LATENCY (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
`ifdef DMEM_DBG_PORT_EN
        ,
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata)
`endif
    );

    pipe_dmem_responder #(
        .DATA_W  (8),
        .ADDR_W  (4),
        .LATENCY (0)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid0),
        .req_we    (req_we0),
        .req_addr  (req_addr0),
        .req_wdata (req_wdata0),
        .req_ready (req_ready0),
        .rsp_valid (rsp_valid0),
        .rsp_rdata (rsp_rdata0)
`ifdef DMEM_DBG_PORT_EN
        ,
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata0)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full request on the LATENCY=2 instance. Returns response data, the
    // number of sampled cycles from accept to the response pulse, and how many
    // of those cycles had req_ready low. Ends one cycle after the pulse.
    task automatic cpu_op(input logic we, input logic [3:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat, output int low);
        @(negedge clk);
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        lat = 0;
        low = 0;
        rd  = 'x;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (!req_ready) low++;
            if (rsp_valid) begin
                lat = i;
                rd  = rsp_rdata;
                break;
            end
        end
        @(negedge clk);
        check("rsp_pulse_single", {31'd0, rsp_valid}, 32'd0);
    endtask

    // One request on the LATENCY=0 instance with req_valid left high; returns
    // at the response cycle with its data and time stamp.
    task automatic op0(input logic we, input logic [3:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output time t);
        @(negedge clk);
        check("z_ready_idle", {31'd0, req_ready0}, 32'd1);
        req_valid0 = 1'b1;
        req_we0    = we;
        req_addr0  = a;
        req_wdata0 = d;
        @(posedge clk);
        @(negedge clk);
        check("z_rsp_valid", {31'd0, rsp_valid0}, 32'd1);
        check("z_ready_low_in_resp", {31'd0, req_ready0}, 32'd0);
        rd = rsp_rdata0;
        t  = $time;
    endtask

`ifdef DMEM_DBG_PORT_EN
    task automatic dbg_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        dbg_we    = 1'b1;
        dbg_addr  = a;
        dbg_wdata = d;
        @(posedge clk);
        #1;
        dbg_we = 1'b0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd, rd1, rd2;
        int         lat, low, n;
        time        t0, t1, t2;

        req_valid  = 1'b0; req_we  = 1'b0; req_addr  = '0; req_wdata  = '0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
`ifdef DMEM_DBG_PORT_EN
        dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
`endif
        rst = 1'b0;
        #1 rst = 1'b1;
        #3;
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // Preload mem[0]=05, mem[1]=03.
`ifdef DMEM_DBG_PORT_EN
        dbg_write(4'd0, 8'h05);
        dbg_write(4'd1, 8'h03);
`else
        cpu_op(1'b1, 4'd0, 8'h05, rd, lat, low);
        check("preload0_ack", {24'd0, rd}, 32'd0);
        cpu_op(1'b1, 4'd1, 8'h03, rd, lat, low);
        check("preload1_ack", {24'd0, rd}, 32'd0);
`endif

        // Load addr 0: two wait cycles then the response cycle.
        cpu_op(1'b0, 4'd0, 8'h00, rd, lat, low);
        check("load0_data", {24'd0, rd}, 32'h05);
        check("load0_latency", lat, 32'd3);
        check("load0_ready_low", low, 32'd3);

        // Store then load.
        cpu_op(1'b1, 4'd2, 8'h08, rd, lat, low);
        check("store2_ack_data", {24'd0, rd}, 32'h00);
        check("store2_latency", lat, 32'd3);
        cpu_op(1'b0, 4'd2, 8'h00, rd, lat, low);
        check("load2_data", {24'd0, rd}, 32'h08);
`ifdef DMEM_DBG_PORT_EN
        dbg_addr = 4'd2;
        #1;
        check("dbg_rdata2", {24'd0, dbg_rdata}, 32'h08);
`endif

        // Reset while a store is in its wait states.
        cpu_op(1'b1, 4'd3, 8'h33, rd, lat, low);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 8'hAA;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        @(negedge clk);
        check("midop_in_wait", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midop_ready_after_release", {31'd0, req_ready}, 32'd1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        check("midop_no_response", n, 32'd0);
`ifdef DMEM_DBG_PORT_EN
        dbg_addr = 4'd3;
        #1;
        check("midop_dbg_mem3", {24'd0, dbg_rdata}, 32'h33);
`endif
        cpu_op(1'b0, 4'd3, 8'h00, rd, lat, low);
        check("midop_mem3_unchanged", {24'd0, rd}, 32'h33);
        cpu_op(1'b0, 4'd0, 8'h00, rd, lat, low);
        check("midop_mem0_kept", {24'd0, rd}, 32'h05);

`ifdef DMEM_DBG_PORT_EN
        // CPU store and debug write to addr 4 on the same edge.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd4; req_wdata = 8'h11;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n = 1;
                break;
            end
        end
        check("collision_ack_seen", n, 32'd1);
        // Store commits on the next edge; put the debug write on it too.
        dbg_we = 1'b1; dbg_addr = 4'd4; dbg_wdata = 8'h22;
        @(posedge clk);
        #1;
        dbg_we = 1'b0;
        @(negedge clk);
        check("collision_dbg_mem4", {24'd0, dbg_rdata}, 32'h11);
        cpu_op(1'b0, 4'd4, 8'h00, rd, lat, low);
        check("collision_load4", {24'd0, rd}, 32'h11);
`endif

        // Top address.
        cpu_op(1'b1, 4'd15, 8'h7F, rd, lat, low);
        check("store15_ack", {24'd0, rd}, 32'h00);
        cpu_op(1'b0, 4'd15, 8'h00, rd, lat, low);
        check("load15_data", {24'd0, rd}, 32'h7F);

        // Zero-latency instance, req_valid held high.
`ifndef DMEM_DBG_PORT_EN
        op0(1'b1, 4'd0, 8'h05, rd, t0);
        check("z_store0_ack", {24'd0, rd}, 32'h00);
        op0(1'b1, 4'd1, 8'h03, rd, t0);
        check("z_store1_ack", {24'd0, rd}, 32'h00);
`endif
        op0(1'b0, 4'd0, 8'h00, rd, t0);
        op0(1'b0, 4'd1, 8'h00, rd1, t1);
        op0(1'b0, 4'd0, 8'h00, rd2, t2);
        req_valid0 = 1'b0;
        check("z_load_a", {24'd0, rd}, 32'h05);
        check("z_load_b", {24'd0, rd1}, 32'h03);
        check("z_load_c", {24'd0, rd2}, 32'h05);
        check("z_period_ab", 32'(t1 - t0), 32'd20);
        check("z_period_bc", 32'(t2 - t1), 32'd20);
        @(negedge clk);
        @(negedge clk);
        check("z_idle_no_extra_rsp", {31'd0, rsp_valid0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
